// File: rtl/pos_move_scheduler.sv
// Position move scheduler: arbitrates manual/auto move requests and paces up/down step pulses.
// Optional macro MAN_PREEMPT_EN lets a manual request pre-empt an in-flight auto move.
module pos_move_scheduler #(
  parameter int unsigned STEP_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       man_req,
  input  logic [7:0] man_target,
  input  logic       auto_req,
  input  logic [7:0] auto_target,
  input  logic       abort,
  input  logic [7:0] pos,
  output logic       man_gnt,
  output logic       auto_gnt,
  output logic       cnt_up,
  output logic       cnt_down,
  output logic       busy,
  output logic       owner,
  output logic       done
);

  localparam int unsigned DW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);

`ifdef MAN_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [7:0]    target;
  logic          preempt;

  // Only an auto-owned move can be taken over, so a granted manual move never re-triggers.
  assign preempt = PREEMPT && man_req && !owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div      <= '0;
      target   <= 8'h80;
      owner    <= 1'b0;
      man_gnt  <= 1'b0;
      auto_gnt <= 1'b0;
      cnt_up   <= 1'b0;
      cnt_down <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      man_gnt  <= 1'b0;
      auto_gnt <= 1'b0;
      cnt_up   <= 1'b0;
      cnt_down <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          div <= '0;
          if (!abort && man_req) begin
            target  <= man_target;
            owner   <= 1'b1;
            man_gnt <= 1'b1;
            busy    <= 1'b1;
            state   <= MOVE;
          end else if (!abort && auto_req) begin
            target   <= auto_target;
            owner    <= 1'b0;
            auto_gnt <= 1'b1;
            busy     <= 1'b1;
            state    <= MOVE;
          end
        end
        MOVE: begin
          if (abort) begin
            div   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (preempt) begin
            target  <= man_target;
            owner   <= 1'b1;
            man_gnt <= 1'b1;
            div     <= '0;
          end else if (pos == target) begin
            done  <= 1'b1;
            div   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (div == DIV_LAST) begin
            if (pos < target) cnt_up <= 1'b1;
            else              cnt_down <= 1'b1;
            div   <= '0;
            state <= SETTLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        SETTLE: begin
          div <= '0;
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (preempt) begin
              target  <= man_target;
              owner   <= 1'b1;
              man_gnt <= 1'b1;
            end
            state <= MOVE;
          end
        end
        default: begin
          div   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pos_move_scheduler.sv
// Directed bench for pos_move_scheduler with STEP_DIV=4 and an up/down position counter model.
module tb_pos_move_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       man_req, auto_req, abort;
  logic [7:0] man_target, auto_target;
  logic [7:0] pos;
  logic       man_gnt, auto_gnt, cnt_up, cnt_down, busy, owner, done;

  logic       load;
  logic [7:0] load_val;

  int vectors = 0;
  int fails   = 0;
  int n_up = 0, n_down = 0, n_done = 0, n_mgnt = 0, n_agnt = 0;
  int n_overlap = 0, n_wide = 0, cyc = 0;
  int up_cyc [64];
  logic prev_up = 1'b0, prev_down = 1'b0;
  int b_up, b_down, b_done, b_mgnt, b_agnt;

  pos_move_scheduler #(.STEP_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .man_req(man_req), .man_target(man_target),
    .auto_req(auto_req), .auto_target(auto_target),
    .abort(abort), .pos(pos),
    .man_gnt(man_gnt), .auto_gnt(auto_gnt),
    .cnt_up(cnt_up), .cnt_down(cnt_down),
    .busy(busy), .owner(owner), .done(done)
  );

  always #5 clk = ~clk;

  // Position counter model plus pulse monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load)          pos <= load_val;
    else if (cnt_up)   pos <= pos + 8'd1;
    else if (cnt_down) pos <= pos - 8'd1;
    if (cnt_up) begin
      n_up <= n_up + 1;
      up_cyc[n_up % 64] <= cyc;
    end
    if (cnt_down) n_down <= n_down + 1;
    if (done)     n_done <= n_done + 1;
    if (man_gnt)  n_mgnt <= n_mgnt + 1;
    if (auto_gnt) n_agnt <= n_agnt + 1;
    if (cnt_up && cnt_down) n_overlap <= n_overlap + 1;
    if ((cnt_up && prev_up) || (cnt_down && prev_down)) n_wide <= n_wide + 1;
    prev_up   <= cnt_up;
    prev_down <= cnt_down;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_up = n_up; b_down = n_down; b_done = n_done; b_mgnt = n_mgnt; b_agnt = n_agnt;
  endtask

  task automatic set_pos(input logic [7:0] v);
    load_val = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_up(input int k, input int bound, input string tag);
    int seen = 0;
    for (int i = 0; i < bound && seen < k; i++) begin
      @(negedge clk);
      if (cnt_up) seen++;
    end
    chk(tag, 32'(seen), 32'(k));
  endtask

  initial begin
    rst_n = 1'b0; man_req = 1'b0; auto_req = 1'b0; abort = 1'b0;
    man_target = 8'h00; auto_target = 8'h00;
    load = 1'b1; load_val = 8'h80;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_pulses", {26'd0, man_gnt, auto_gnt, cnt_up, cnt_down, done, 1'b0}, 0);
    rst_n = 1'b1;
    load = 1'b0;
    @(negedge clk);

    // Auto move 0x80 -> 0x83
    snap();
    auto_req = 1'b1; auto_target = 8'h83;
    @(negedge clk);
    chk("s1_agnt", 32'(auto_gnt), 1);
    chk("s1_busy", 32'(busy), 1);
    auto_req = 1'b0;
    wait_done(40, "s1_done_seen");
    chk("s1_busy_after", 32'(busy), 0);
    @(negedge clk);
    chk("s1_pos", 32'(pos), 32'h83);
    chk("s1_ups", 32'(n_up - b_up), 3);
    chk("s1_downs", 32'(n_down - b_down), 0);
    chk("s1_dones", 32'(n_done - b_done), 1);
    chk("s1_agnts", 32'(n_agnt - b_agnt), 1);
    chk("s1_gap1", 32'(up_cyc[(b_up + 1) % 64] - up_cyc[b_up % 64]), 5);
    chk("s1_gap2", 32'(up_cyc[(b_up + 2) % 64] - up_cyc[(b_up + 1) % 64]), 5);
    chk("s1_owner", 32'(owner), 0);

    // Simultaneous requests, manual wins, auto granted back-to-back
    set_pos(8'h80);
    snap();
    man_req = 1'b1; man_target = 8'h7E;
    auto_req = 1'b1; auto_target = 8'h90;
    @(negedge clk);
    chk("s2_mgnt", 32'(man_gnt), 1);
    chk("s2_agnt_lose", 32'(auto_gnt), 0);
    chk("s2_owner", 32'(owner), 1);
    man_req = 1'b0;
    wait_done(60, "s2_man_done_seen");
    @(negedge clk);
    chk("s2_agnt_b2b", 32'(auto_gnt), 1);
    chk("s2_pos_man", 32'(pos), 32'h7E);
    chk("s2_downs", 32'(n_down - b_down), 2);
    chk("s2_ups_man", 32'(n_up - b_up), 0);
    chk("s2_agnts_man", 32'(n_agnt - b_agnt), 0);
    auto_req = 1'b0;
    snap();
    wait_done(200, "s2_auto_done_seen");
    @(negedge clk);
    chk("s2_pos_auto", 32'(pos), 32'h90);
    chk("s2_ups_auto", 32'(n_up - b_up), 18);
    chk("s2_owner_auto", 32'(owner), 0);

    // Target equals position at grant
    set_pos(8'h80);
    snap();
    man_req = 1'b1; man_target = 8'h80;
    @(negedge clk);
    chk("s3_mgnt", 32'(man_gnt), 1);
    chk("s3_done_early", 32'(done), 0);
    man_req = 1'b0;
    @(negedge clk);
    chk("s3_done", 32'(done), 1);
    @(negedge clk);
    chk("s3_steps", 32'((n_up - b_up) + (n_down - b_down)), 0);
    chk("s3_busy", 32'(busy), 0);

    // Abort after the second step of a move to 0xFF
    snap();
    auto_req = 1'b1; auto_target = 8'hFF;
    @(negedge clk);
    auto_req = 1'b0;
    wait_up(2, 30, "s4_two_steps");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("s4_busy", 32'(busy), 0);
    chk("s4_up_cut", 32'(cnt_up), 0);
    repeat (20) @(negedge clk);
    chk("s4_pos", 32'(pos), 32'h82);
    chk("s4_no_done", 32'(n_done - b_done), 0);
    chk("s4_ups", 32'(n_up - b_up), 2);

    // Abort in IDLE blocks grants
    snap();
    abort = 1'b1; auto_req = 1'b1; auto_target = 8'h90;
    repeat (3) @(negedge clk);
    chk("s4_idle_abort_gnt", 32'(n_agnt - b_agnt), 0);
    chk("s4_idle_abort_busy", 32'(busy), 0);
    abort = 1'b0; auto_req = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-move
    snap();
    man_req = 1'b1; man_target = 8'h90;
    @(negedge clk);
    man_req = 1'b0;
    repeat (6) @(negedge clk);
    chk("s5_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_busy", 32'(busy), 0);
    chk("s5_rst_owner", 32'(owner), 0);
    chk("s5_rst_pulses", {27'd0, man_gnt, auto_gnt, cnt_up, cnt_down, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("s5_no_done", 32'(n_done - b_done), 0);
    chk("s5_idle_busy", 32'(busy), 0);
    set_pos(8'h80);
    snap();
    auto_req = 1'b1; auto_target = 8'h84;
    @(negedge clk);
    chk("s5_agnt", 32'(auto_gnt), 1);
    auto_req = 1'b0;
    wait_done(60, "s5_done_seen");
    @(negedge clk);
    chk("s5_pos", 32'(pos), 32'h84);

    // Manual request during an auto move
    set_pos(8'h80);
    snap();
    auto_req = 1'b1; auto_target = 8'hA0;
    @(negedge clk);
    chk("s6_agnt", 32'(auto_gnt), 1);
    auto_req = 1'b0;
    wait_up(1, 20, "s6_first_step");
    man_req = 1'b1; man_target = 8'h70;
    @(negedge clk);
`ifdef MAN_PREEMPT_EN
    chk("s6_preempt_mgnt", 32'(man_gnt), 1);
    chk("s6_preempt_owner", 32'(owner), 1);
    man_req = 1'b0;
    wait_done(400, "s6_man_done_seen");
    @(negedge clk);
    chk("s6_pos", 32'(pos), 32'h70);
    chk("s6_dones", 32'(n_done - b_done), 1);
`else
    chk("s6_wait_mgnt", 32'(man_gnt), 0);
    chk("s6_wait_owner", 32'(owner), 0);
    wait_done(300, "s6_auto_done_seen");
    @(negedge clk);
    chk("s6_pos_auto", 32'(pos), 32'hA0);
    chk("s6_mgnt_after", 32'(man_gnt), 1);
    man_req = 1'b0;
    wait_done(400, "s6_man_done_seen");
    @(negedge clk);
    chk("s6_pos", 32'(pos), 32'h70);
    chk("s6_dones", 32'(n_done - b_done), 2);
`endif

    chk("overlap", 32'(n_overlap), 0);
    chk("wide_pulse", 32'(n_wide), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
